// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, pixel record and writer FSM states
// for the pixel sink and its buffer.
package fb_pkg;

    localparam int H_RES      = 640;
    localparam int V_RES      = 480;
    localparam int FB_SIZE    = H_RES * V_RES;
    localparam int FIFO_DEPTH = 8;
    localparam int DROP_W     = 16;

    typedef logic [9:0]  x_t;
    typedef logic [8:0]  y_t;
    typedef logic [18:0] fb_addr_t;

    typedef struct packed {
        x_t   x;
        y_t   y;
        logic color;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        CLEAR
    } pw_state_t;

    // y*640 + x built from y*512 + y*128 so no multiplier is inferred.
    function automatic fb_addr_t pix_addr(input x_t x, input y_t y);
        fb_addr_t yy;
        yy = {10'd0, y};
        return (yy << 9) + (yy << 7) + {9'd0, x};
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of pixel records; the head is visible on rd_data
// whenever empty is low. Caller never pushes when full or pops when empty.
module pixel_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  pixel_t wr_data,
    input  logic   pop,
    output pixel_t rd_data,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    pixel_t        mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/pixel_writer.sv
// Pixel stream sink: buffers (x, y, colour) writes, range-checks them and
// drives a 1-bpp framebuffer write port; also performs a full-screen clear.
module pixel_writer
    import fb_pkg::*;
#(
    parameter int CLEAR_LEN = FB_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    // Handshake: a pixel transfers on any posedge where pix_valid && pix_ready.
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [9:0]        pix_x,
    input  logic [8:0]        pix_y,
    input  logic              pix_color,
    input  logic              clear_req,
    input  logic              clear_color,
    output logic [18:0]       fb_addr,
    output logic              fb_wdata,
    output logic              fb_we,
    input  logic              fb_wait,
    output logic              busy,
    output logic              clear_done,
    output logic [DROP_W-1:0] drop_cnt,
    output pw_state_t         dbg_state
);

    localparam x_t       X_LIM     = x_t'(H_RES);
    localparam y_t       Y_LIM     = y_t'(V_RES);
    localparam fb_addr_t LAST_ADDR = fb_addr_t'(CLEAR_LEN - 1);

    pw_state_t state, state_nxt;
    pixel_t    head;
    logic      fifo_full, fifo_empty;
    logic      clear_pending, clear_col;
    logic      accept, in_range, push;
    logic      pop, load_pix, start_clear, step_clear, finish_clear, stop_wr;

    assign in_range  = (pix_x < X_LIM) && (pix_y < Y_LIM);
    assign pix_ready = reset && !fifo_full && !clear_pending && (state != CLEAR);
    assign accept    = pix_valid && pix_ready;
    assign push      = accept && in_range;
    assign busy      = !fifo_empty || (state != IDLE) || clear_pending;
    assign dbg_state = state;

    pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data ('{x: pix_x, y: pix_y, color: pix_color}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        pop          = 1'b0;
        load_pix     = 1'b0;
        start_clear  = 1'b0;
        step_clear   = 1'b0;
        finish_clear = 1'b0;
        stop_wr      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    load_pix  = 1'b1;
                    state_nxt = WRITE;
                end else if (clear_pending) begin
                    start_clear = 1'b1;
                    state_nxt   = CLEAR;
                end
            end
            WRITE: begin
                // Nothing moves while the memory stalls the current write.
                if (!fb_wait) begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        load_pix = 1'b1;
                    end else begin
                        stop_wr   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            CLEAR: begin
                if (!fb_wait) begin
                    if (fb_addr == LAST_ADDR) begin
                        finish_clear = 1'b1;
                        state_nxt    = IDLE;
                    end else begin
                        step_clear = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fb_addr       <= '0;
            fb_wdata      <= 1'b0;
            fb_we         <= 1'b0;
            clear_done    <= 1'b0;
            clear_pending <= 1'b0;
            clear_col     <= 1'b0;
            drop_cnt      <= '0;
        end else begin
            clear_done <= finish_clear;
            if (load_pix) begin
                fb_addr  <= pix_addr(head.x, head.y);
                fb_wdata <= head.color;
                fb_we    <= 1'b1;
            end else if (start_clear) begin
                fb_addr  <= '0;
                fb_wdata <= clear_col;
                fb_we    <= 1'b1;
            end else if (step_clear) begin
                fb_addr <= fb_addr + 19'd1;
            end else if (stop_wr || finish_clear) begin
                fb_we <= 1'b0;
            end
            // A second request while one is pending or running is dropped.
            if (clear_req && !clear_pending && (state != CLEAR)) begin
                clear_pending <= 1'b1;
                clear_col     <= clear_color;
            end else if (start_clear) begin
                clear_pending <= 1'b0;
            end
            if (accept && !in_range && (drop_cnt != '1))
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: single-pixel vector table, burst, stall,
// clear and reset-during-clear sequences, with a write scoreboard.
module tb_pixel_writer;
    import fb_pkg::*;

    // Clear length is shortened so the fill sequence stays brief.
    localparam int CLR = 2048;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [9:0]  pix_x = '0;
    logic [8:0]  pix_y = '0;
    logic        pix_color = 1'b0;
    logic        clear_req = 1'b0;
    logic        clear_color = 1'b0;
    logic [18:0] fb_addr;
    logic        fb_wdata;
    logic        fb_we;
    logic        fb_wait = 1'b0;
    logic        busy;
    logic        clear_done;
    logic [15:0] drop_cnt;
    pw_state_t   dbg_state;

    pixel_writer #(.CLEAR_LEN(CLR)) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_color   (pix_color),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .fb_addr     (fb_addr),
        .fb_wdata    (fb_wdata),
        .fb_we       (fb_we),
        .fb_wait     (fb_wait),
        .busy        (busy),
        .clear_done  (clear_done),
        .drop_cnt    (drop_cnt),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_bad = 0;
    logic [19:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic clear_mode = 1'b0;
    logic ignore_wr  = 1'b0;
    logic clr_color  = 1'b0;
    int   nwr = 0;
    int   wr_cyc [0:255];
    int   clr_next = 0;
    int   clr_total = 0;
    int   clr_bad = 0;
    int   last_clr_cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;

    always @(negedge clk) begin
        if (reset && !ignore_wr) begin
            if (fb_we && !fb_wait) begin
                if (exp_q.size() > 0) begin
                    chk("pixel_write", {12'd0, fb_wdata, fb_addr}, {12'd0, exp_q.pop_front()});
                    if (nwr < 256) wr_cyc[nwr] = cyc;
                    nwr++;
                end else if (clear_mode) begin
                    if (fb_addr !== 19'(clr_next) || fb_wdata !== clr_color) clr_bad++;
                    clr_next++;
                    last_clr_cyc = cyc;
                end else begin
                    chk("spurious_we", {31'd0, fb_we}, 32'd0);
                end
            end
            if (clear_done) begin
                done_cnt++;
                done_cyc  = cyc;
                clr_total = clr_next;
                clr_next  = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [9:0] x, input logic [8:0] y, input logic c, output int waits);
        logic        acc;
        logic [18:0] a;
        int          n;
        pix_valid = 1'b1;
        pix_x     = x;
        pix_y     = y;
        pix_color = c;
        waits     = 0;
        acc       = 1'b0;
        n         = 0;
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = pix_ready;
            @(posedge clk);
            #1;
            if (!acc) waits++;
            n++;
        end
        chk("send_accepted", {31'd0, acc}, 32'd1);
        if (acc && x < 10'd640 && y < 9'd480) begin
            a = 19'(int'(y) * 640 + int'(x));
            exp_q.push_back({c, a});
        end
    endtask

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic        c;
        logic        we;
        logic [18:0] addr;
    } vec_t;

    task automatic apply_vec(input vec_t v, input string name);
        int w;
        send(v.x, v.y, v.c, w);
        pix_valid = 1'b0;
        @(negedge clk);
        chk({name, "_no_we_yet"}, {31'd0, fb_we}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({name, "_we"}, {31'd0, fb_we}, {31'd0, v.we});
        if (v.we) begin
            chk({name, "_addr"}, {13'd0, fb_addr}, {13'd0, v.addr});
            chk({name, "_wdata"}, {31'd0, fb_wdata}, {31'd0, v.c});
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        chk({name, "_idle"}, {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear(input logic col);
        clear_req   = 1'b1;
        clear_color = col;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs [9];

    initial begin
        int w, wsum, base, acc_n, n_drop;
        logic a, hit;

        vecs[0] = '{10'd5,    9'd2,   1'b1, 1'b1, 19'd1285};
        vecs[1] = '{10'd0,    9'd0,   1'b0, 1'b1, 19'd0};
        vecs[2] = '{10'd639,  9'd479, 1'b1, 1'b1, 19'd307199};
        vecs[3] = '{10'd639,  9'd0,   1'b0, 1'b1, 19'd639};
        vecs[4] = '{10'd0,    9'd479, 1'b1, 1'b1, 19'd306560};
        vecs[5] = '{10'd100,  9'd200, 1'b1, 1'b1, 19'd128100};
        vecs[6] = '{10'd640,  9'd10,  1'b1, 1'b0, 19'd0};
        vecs[7] = '{10'd3,    9'd480, 1'b0, 1'b0, 19'd0};
        vecs[8] = '{10'd1023, 9'd511, 1'b1, 1'b0, 19'd0};

        // Reset state
        @(negedge clk);
        chk("rst_ready", {31'd0, pix_ready}, 32'd0);
        chk("rst_we", {31'd0, fb_we}, 32'd0);
        chk("rst_addr_data", {12'd0, fb_wdata, fb_addr}, 32'd0);
        chk("rst_busy_done", {30'd0, busy, clear_done}, 32'd0);
        chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, pix_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Single pixels, in and out of range
        n_drop = 0;
        for (int i = 0; i < 9; i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
            if (!vecs[i].we) n_drop++;
        end
        chk("drop_cnt", {16'd0, drop_cnt}, n_drop);

        // Burst of 20 with no stall
        base = nwr;
        wsum = 0;
        for (int i = 0; i < 20; i++) begin
            send(10'((i * 31) % 640), 9'(i * 3 + 100), i[0], w);
            wsum += w;
        end
        pix_valid = 1'b0;
        wait_idle(60, "burst");
        chk("burst_ready_drops", wsum, 0);
        chk("burst_count", nwr - base, 20);
        chk("burst_back_to_back", wr_cyc[base + 19] - wr_cyc[base], 19);

        // Burst against a 12+ cycle memory stall
        fb_wait = 1'b1;
        base    = nwr;
        acc_n   = 0;
        pix_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            pix_x     = 10'(acc_n * 50 + 3);
            pix_y     = 9'(acc_n + 7);
            pix_color = acc_n[0];
            @(negedge clk);
            a = pix_ready;
            @(posedge clk);
            #1;
            if (a) begin
                exp_q.push_back({pix_color, 19'(int'(pix_y) * 640 + int'(pix_x))});
                acc_n++;
            end
        end
        @(negedge clk);
        chk("stall_ready_low", {31'd0, pix_ready}, 32'd0);
        chk("stall_accepted", acc_n, 9);
        chk("stall_no_write", nwr - base, 0);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        fb_wait   = 1'b0;
        wait_idle(40, "stall");
        chk("stall_drained", nwr - base, 9);
        chk("stall_queue_empty", exp_q.size(), 0);

        // Buffered pixels then clear to black; a second request is ignored
        fb_wait = 1'b1;
        base    = nwr;
        send(10'd11, 9'd1, 1'b1, w);
        send(10'd12, 9'd2, 1'b0, w);
        send(10'd13, 9'd3, 1'b1, w);
        pix_valid = 1'b0;
        clr_color = 1'b0;
        pulse_clear(1'b0);
        @(negedge clk);
        chk("clear_ready_low", {31'd0, pix_ready}, 32'd0);
        chk("clear_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        pulse_clear(1'b1);
        clear_mode = 1'b1;
        fb_wait    = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < CLR + 200 && !hit; i++) begin
            @(negedge clk);
            if (done_cnt > 0) hit = 1'b1;
        end
        chk("clear_finished", {31'd0, hit}, 32'd1);
        repeat (5) @(negedge clk);
        chk("clear_pixels_first", nwr - base, 3);
        chk("clear_writes", clr_total, CLR);
        chk("clear_bad_writes", clr_bad, 0);
        chk("clear_done_pulses", done_cnt, 1);
        chk("clear_done_timing", done_cyc - last_clr_cyc, 1);
        chk("clear_after_ready", {31'd0, pix_ready}, 32'd1);
        chk("clear_after_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        clear_mode = 1'b0;

        // Reset in the middle of a clear
        ignore_wr = 1'b1;
        pulse_clear(1'b1);
        hit = 1'b0;
        for (int i = 0; i < 1500 && !hit; i++) begin
            @(negedge clk);
            if (dbg_state == CLEAR && fb_addr == 19'd1000) hit = 1'b1;
        end
        chk("reach_addr_1000", {31'd0, hit}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_we", {31'd0, fb_we}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_state", {30'd0, dbg_state}, {30'd0, IDLE});
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("abort_hold_we", {31'd0, fb_we}, 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        ignore_wr = 1'b0;
        @(negedge clk);
        chk("abort_ready", {31'd0, pix_ready}, 32'd1);
        chk("abort_drop_clr", {16'd0, drop_cnt}, 32'd0);
        @(posedge clk);
        #1;
        apply_vec('{10'd7, 9'd3, 1'b1, 1'b1, 19'd1927}, "post_abort");
        wait_idle(20, "post_abort");

        chk("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
